// File: rtl/conc_vector_player.sv
// Vector-memory stimulus sequencer: plays loaded {obs, payload} entries one per accepted
// beat with valid/ready backpressure, optional looping and saturating beat/loop counters.
module conc_vector_player #(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W:0]   ld_data,
    output logic              ld_err,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_obs,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic [CNT_W-1:0]  loop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_obs_q;
    logic              done_q;
    logic              ld_err_q;
    logic [CNT_W-1:0]  beat_cnt_q;
    logic [CNT_W-1:0]  loop_cnt_q;

    logic [DATA_W:0]   mem_q [DEPTH];
    logic [ADDR_W-1:0] last_eff;
    logic [ADDR_W-1:0] pc_inc;
    logic              accept;

    // Out-of-range last_addr only exists when DEPTH is not a power of two.
    generate
        if (DEPTH == (1 << ADDR_W)) begin : g_no_clamp
            assign last_eff = last_addr;
        end else begin : g_clamp
            assign last_eff = (last_addr > MAX_ADDR) ? MAX_ADDR : last_addr;
        end
    endgenerate

    assign pc_inc = pc_q + ADDR_W'(1);
    assign accept = out_valid_q & out_ready;

    // Memory is not reset; per-entry decode drops writes to addresses beyond DEPTH-1.
    always_ff @(posedge clk) begin
        if (ld_we && state_q != S_RUN) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ld_addr == ADDR_W'(i)) mem_q[i] <= ld_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_obs_q   <= 1'b0;
            done_q      <= 1'b0;
            ld_err_q    <= 1'b0;
            beat_cnt_q  <= '0;
            loop_cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (stop) begin
                        state_q <= S_IDLE;
                    end else if (start) begin
                        state_q                 <= S_RUN;
                        pc_q                    <= '0;
                        {out_obs_q, out_data_q} <= mem_q[0];
                        out_valid_q             <= 1'b1;
                        beat_cnt_q              <= '0;
                        loop_cnt_q              <= '0;
                        ld_err_q                <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (ld_we) ld_err_q <= 1'b1;
                    // stop outranks a same-cycle accept: the beat is discarded.
                    if (stop) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end else if (accept) begin
                        if (beat_cnt_q != '1) beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        if (pc_q != last_eff) begin
                            pc_q                    <= pc_inc;
                            {out_obs_q, out_data_q} <= mem_q[pc_inc];
                        end else if (loop_en) begin
                            pc_q                    <= '0;
                            {out_obs_q, out_data_q} <= mem_q[0];
                            if (loop_cnt_q != '1) loop_cnt_q <= loop_cnt_q + CNT_W'(1);
                        end else begin
                            out_valid_q <= 1'b0;
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign ld_err    = ld_err_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_obs   = out_obs_q;
    assign pc        = pc_q;
    assign busy      = (state_q == S_RUN);
    assign done      = done_q;
    assign beat_cnt  = beat_cnt_q;
    assign loop_cnt  = loop_cnt_q;

endmodule

// File: tb/tb_conc_vector_player.sv
// Directed bench for conc_vector_player: small DEPTH/CNT_W so clamping and saturation are reachable.
module tb_conc_vector_player;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 5;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W:0]   ld_data;
    logic              ld_err;
    logic              start, stop, loop_en;
    logic [ADDR_W-1:0] last_addr;
    logic              out_valid, out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_obs;
    logic [ADDR_W-1:0] pc;
    logic              busy, done;
    logic [CNT_W-1:0]  beat_cnt, loop_cnt;

    int n_chk = 0;
    int n_err = 0;

    logic [DATA_W-1:0] vec [DEPTH];
    logic              obs [DEPTH];

    conc_vector_player #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_err(ld_err), .start(start), .stop(stop), .loop_en(loop_en), .last_addr(last_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_obs(out_obs),
        .pc(pc), .busy(busy), .done(done), .beat_cnt(beat_cnt), .loop_cnt(loop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_chk++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_pc"},    64'(pc),        64'd0);
        chk({tag, "_data"},  64'(out_data),  64'd0);
        chk({tag, "_obs"},   64'(out_obs),   64'd0);
        chk({tag, "_busy"},  64'(busy),      64'd0);
        chk({tag, "_done"},  64'(done),      64'd0);
        chk({tag, "_lderr"}, 64'(ld_err),    64'd0);
        chk({tag, "_beat"},  64'(beat_cnt),  64'd0);
        chk({tag, "_loop"},  64'(loop_cnt),  64'd0);
    endtask

    task automatic chk_vec(input string tag, input int i);
        chk($sformatf("%s_valid%0d", tag, i), 64'(out_valid), 64'd1);
        chk($sformatf("%s_pc%0d",    tag, i), 64'(pc),        64'(i));
        chk($sformatf("%s_data%0d",  tag, i), 64'(out_data),  64'(vec[i]));
        chk($sformatf("%s_obs%0d",   tag, i), 64'(out_obs),   64'(obs[i]));
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) vec[i] = 32'hA5A5_0000 + 32'(i * 17);
        obs[0] = 1'b1; obs[1] = 1'b0; obs[2] = 1'b0; obs[3] = 1'b1; obs[4] = 1'b1;

        rst = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        start = 1'b0; stop = 1'b0; loop_en = 1'b0; last_addr = 3'd3; out_ready = 1'b0;
        #3;
        chk_reset("por");
        tick();
        rst = 1'b1;
        tick();

        for (int i = 0; i < DEPTH; i++) begin
            ld_we = 1'b1; ld_addr = ADDR_W'(i); ld_data = {obs[i], vec[i]};
            tick();
        end
        ld_we = 1'b0;

        // back-to-back playback of entries 0..3
        last_addr = 3'd3; loop_en = 1'b0; out_ready = 1'b1;
        do_start();
        chk("t1_beat0", 64'(beat_cnt), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk_vec("t1", i);
            tick();
        end
        chk("t1_valid_end", 64'(out_valid), 64'd0);
        chk("t1_done",      64'(done),      64'd1);
        chk("t1_busy",      64'(busy),      64'd0);
        chk("t1_beat",      64'(beat_cnt),  64'd4);
        tick();
        chk("t1_done_pulse", 64'(done), 64'd0);

        // start+stop together from DONE: stop wins, counters untouched
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("ss_busy",  64'(busy),      64'd0);
        chk("ss_valid", 64'(out_valid), 64'd0);
        chk("ss_beat",  64'(beat_cnt),  64'd4);

        // backpressure on entry 1 for three cycles
        out_ready = 1'b0;
        do_start();
        chk_vec("t2a", 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_vec($sformatf("t2stall%0d", k), 1);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            chk_vec("t2b", i);
            tick();
        end
        chk("t2_done", 64'(done),     64'd1);
        chk("t2_beat", 64'(beat_cnt), 64'd4);

        // looping over entries 0..1, then counter saturation at 7
        last_addr = 3'd1; loop_en = 1'b1;
        do_start();
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t3_pc%0d", i),   64'(pc),   64'(i % 2));
            chk($sformatf("t3_done%0d", i), 64'(done), 64'd0);
            tick();
        end
        chk("t3_loop", 64'(loop_cnt), 64'd3);
        chk("t3_beat", 64'(beat_cnt), 64'd6);
        chk("t3_busy", 64'(busy),     64'd1);
        chk("t3_pc",   64'(pc),       64'd0);
        repeat (4) tick();
        chk("sat_beat", 64'(beat_cnt), 64'd7);
        chk("sat_loop", 64'(loop_cnt), 64'd5);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t3_stop_busy",  64'(busy),      64'd0);
        chk("t3_stop_valid", 64'(out_valid), 64'd0);

        // stop coincident with accept at pc=2
        last_addr = 3'd3; loop_en = 1'b0; out_ready = 1'b1;
        do_start();
        tick();
        tick();
        chk("t4_pc2",  64'(pc),       64'd2);
        chk("t4_beat", 64'(beat_cnt), 64'd2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t4_valid",    64'(out_valid), 64'd0);
        chk("t4_busy",     64'(busy),      64'd0);
        chk("t4_beat_end", 64'(beat_cnt),  64'd2);
        chk("t4_data",     64'(out_data),  64'(vec[2]));

        // last_addr beyond DEPTH-1 clamps to entry 4
        last_addr = 3'd7;
        do_start();
        for (int i = 0; i < DEPTH; i++) begin
            chk_vec("t5", i);
            tick();
        end
        chk("t5_done", 64'(done),     64'd1);
        chk("t5_beat", 64'(beat_cnt), 64'd5);

        // load attempt while running is dropped and flagged
        out_ready = 1'b0; last_addr = 3'd3;
        do_start();
        ld_we = 1'b1; ld_addr = 3'd0; ld_data = {1'b0, 32'hDEAD_BEEF};
        tick();
        ld_we = 1'b0;
        chk("t6_lderr", 64'(ld_err),   64'd1);
        chk("t6_data",  64'(out_data), 64'(vec[0]));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t6_lderr_sticky", 64'(ld_err), 64'd1);
        do_start();
        chk("t6_lderr_clr", 64'(ld_err),   64'd0);
        chk("t6_mem_data",  64'(out_data), 64'(vec[0]));
        chk("t6_mem_obs",   64'(out_obs),  64'(obs[0]));

        // asynchronous reset mid-run
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        ld_we = 1'b1;
        tick();
        ld_we = 1'b0;
        chk("t7_pre_pc",    64'(pc),     64'd1);
        chk("t7_pre_lderr", 64'(ld_err), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk_reset("arst");
        tick();
        rst = 1'b1;
        tick();
        chk("t7_idle_busy", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
